// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the address sequencer.
package addr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/addr_step.sv
// Combinational next-address step: add/sub by stride, optional window wrap.
// Window wrap is enabled by defining ADDR_SEQ_WRAP_EN.
module addr_step
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic              dir,
  input  logic [ADDR_W-1:0] lo_bound,
  input  logic [ADDR_W-1:0] hi_bound,
  output logic [ADDR_W-1:0] nxt
);

  // Extra MSB carries the carry-out (up) or borrow (down).
  logic [ADDR_W:0] sum;
  logic [ADDR_W:0] diff;

  assign sum  = {1'b0, addr} + {1'b0, stride};
  assign diff = {1'b0, addr} - {1'b0, stride};

  always_comb begin
    nxt = (dir == DIR_DOWN) ? diff[ADDR_W-1:0] : sum[ADDR_W-1:0];
`ifdef ADDR_SEQ_WRAP_EN
    if (dir == DIR_UP && (sum[ADDR_W] || sum[ADDR_W-1:0] > hi_bound))
      nxt = lo_bound;
    if (dir == DIR_DOWN && (diff[ADDR_W] || diff[ADDR_W-1:0] < lo_bound))
      nxt = hi_bound;
`endif
  end

`ifndef ADDR_SEQ_WRAP_EN
  logic unused_bounds;
  assign unused_bounds = ^{lo_bound, hi_bound};
`endif

endmodule

// File: rtl/addr_sequencer.sv
// Burst address sequencer: direct load, strided up/down bursts with ready backpressure.
// Optional lo/hi window wrap when ADDR_SEQ_WRAP_EN is defined.
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] stride,
  input  logic              dir,
  input  logic [ADDR_W-1:0] lo_bound,
  input  logic [ADDR_W-1:0] hi_bound,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  state_t              state;
  logic [LEN_W-1:0]    count;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   stride_q;
  logic                dir_q;
  logic [ADDR_W-1:0]   lo_q;
  logic [ADDR_W-1:0]   hi_q;
  logic [ADDR_W-1:0]   nxt;

  addr_step #(.ADDR_W(ADDR_W)) u_step (
    .addr     (addr_q),
    .stride   (stride_q),
    .dir      (dir_q),
    .lo_bound (lo_q),
    .hi_bound (hi_q),
    .nxt      (nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      dir_q    <= DIR_UP;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start wins over load; the first beat is the current address.
          if (start) begin
            count    <= len;
            stride_q <= stride;
            dir_q    <= dir;
            lo_q     <= lo_bound;
            hi_q     <= hi_bound;
            state    <= (len == '0) ? DONE : BURST;
          end else if (load) begin
            addr_q <= data_in;
          end
        end
        BURST: begin
          if (ready) begin
            addr_q <= nxt;
            count  <= count - 1'b1;
            if (count == LEN_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign addr_out = addr_q;
  assign valid    = (state == BURST);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed self-checking bench for addr_sequencer (both ADDR_SEQ_WRAP_EN builds).
module tb_addr_sequencer;

  localparam int AW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] data_in = '0;
  logic [AW-1:0] stride = '0;
  logic [AW-1:0] lo_bound = '0;
  logic [AW-1:0] hi_bound = '0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] addr_out;
  logic          valid;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  addr_sequencer #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .start    (start),
    .len      (len),
    .stride   (stride),
    .dir      (dir),
    .lo_bound (lo_bound),
    .hi_bound (hi_bound),
    .ready    (ready),
    .addr_out (addr_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load base, run one burst against exp_q; stall[i] drops ready on cycle i.
  // With noise set, load and start stay high through the burst and must be ignored.
  task automatic burst(input string name, input logic [7:0] base, input logic [3:0] blen,
                       input logic [7:0] bstride, input logic bdir,
                       input logic [7:0] lo, input logic [7:0] hi,
                       input logic [39:0] stall, input logic noise, input logic [7:0] fin);
    int   nb;
    logic seen;
    nb   = 0;
    seen = 1'b0;
    @(negedge clk);
    load = 1'b1; data_in = base;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1; len = blen; stride = bstride; dir = bdir;
    lo_bound = lo; hi_bound = hi; ready = 1'b0;
    @(negedge clk);
    if (noise) begin
      load = 1'b1; data_in = 8'h77;
    end else begin
      start = 1'b0;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) begin
        seen = 1'b1;
        chk({name, ":done_busy"}, 32'(busy), 32'd1);
        chk({name, ":done_valid"}, 32'(valid), 32'd0);
        load = 1'b0; start = 1'b0;
        break;
      end
      ready = !stall[cyc];
      if (valid) begin
        if (nb >= exp_q.size())
          chk({name, ":extra_beat"}, 32'(nb), 32'(exp_q.size()));
        else if (ready) begin
          chk({name, ":beat"}, 32'(addr_out), 32'(exp_q[nb]));
          nb++;
        end else
          chk({name, ":hold"}, 32'(addr_out), 32'(exp_q[nb]));
      end
      @(negedge clk);
    end
    ready = 1'b0; load = 1'b0; start = 1'b0;
    chk({name, ":done_seen"}, 32'(seen), 32'd1);
    chk({name, ":beats"}, 32'(nb), 32'(exp_q.size()));
    chk({name, ":final_addr"}, 32'(addr_out), 32'(fin));
    @(negedge clk);
    chk({name, ":idle_done"}, 32'(done), 32'd0);
    chk({name, ":idle_busy"}, 32'(busy), 32'd0);
    chk({name, ":idle_addr"}, 32'(addr_out), 32'(fin));
  endtask

  initial begin
    int odd;
    #12;
    chk("rst_addr", 32'(addr_out), 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    load = 1'b1; data_in = 8'hA5;
    @(negedge clk);
    load = 1'b0;
    chk("load_a5", 32'(addr_out), 32'hA5);
    chk("load_busy", 32'(busy), 32'd0);

    exp_q = '{8'h10, 8'h12, 8'h14, 8'h16};
    burst("up", 8'h10, 4'd4, 8'd2, 1'b0, 8'h00, 8'hFF, 40'h0, 1'b0, 8'h18);
    burst("bp", 8'h10, 4'd4, 8'd2, 1'b0, 8'h00, 8'hFF, 40'h6, 1'b0, 8'h18);
    burst("noise", 8'h10, 4'd4, 8'd2, 1'b0, 8'h00, 8'hFF, 40'h0, 1'b1, 8'h18);

`ifdef ADDR_SEQ_WRAP_EN
    exp_q = '{8'hFE, 8'hFF, 8'hF0};
    burst("wrap_up", 8'hFE, 4'd3, 8'd1, 1'b0, 8'hF0, 8'hFF, 40'h0, 1'b0, 8'hF1);
    exp_q = '{8'h02, 8'h00, 8'hF0};
    burst("wrap_dn", 8'h02, 4'd3, 8'd2, 1'b1, 8'h00, 8'hF0, 40'h0, 1'b0, 8'hEE);
`else
    exp_q = '{8'hFE, 8'hFF, 8'h00};
    burst("mod_up", 8'hFE, 4'd3, 8'd1, 1'b0, 8'hF0, 8'hFF, 40'h0, 1'b0, 8'h01);
    exp_q = '{8'h02, 8'h00, 8'hFE};
    burst("mod_dn", 8'h02, 4'd3, 8'd2, 1'b1, 8'h00, 8'hF0, 40'h0, 1'b0, 8'hFC);
`endif

    exp_q = {};
    burst("len0", 8'h3C, 4'd0, 8'd5, 1'b0, 8'h00, 8'hFF, 40'h0, 1'b0, 8'h3C);

    // Abort a stalled burst with an asynchronous reset between clock edges.
    @(negedge clk);
    load = 1'b1; data_in = 8'h35;
    @(negedge clk);
    load = 1'b0;
    start = 1'b1; len = 4'd8; stride = 8'd1; dir = 1'b0; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("abort_pre_addr", 32'(addr_out), 32'h35);
    chk("abort_pre_valid", 32'(valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_addr", 32'(addr_out), 32'h0);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    odd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) odd++;
    end
    chk("abort_quiet", 32'(odd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addr_sequencer.md
ADDR_SEQUENCER -- requirements
Module: addr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, address/data width in bits.
REQ-002 Parameter LEN_W, default 4, burst-length counter width in bits.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  direct-load strobe, honoured only in IDLE.
REQ-006 data_in  input  ADDR_W  value written to address register on load.
REQ-007 start  input  1  burst request, honoured only in IDLE.
REQ-008 len  input  LEN_W  burst beat count, sampled on start.
REQ-009 stride  input  ADDR_W  unsigned step, sampled on start.
REQ-010 dir  input  1  0 = ascending, 1 = descending, sampled on start.
REQ-011 lo_bound / hi_bound  input  ADDR_W each  wrap window, sampled on start.
REQ-012 ready  input  1  consumer accepts current beat.
REQ-013 addr_out  output  ADDR_W  current address register value.
REQ-014 valid  output  1  high in BURST only.
REQ-015 busy  output  1  high in BURST and DONE.
REQ-016 done  output  1  one-cycle pulse in DONE.

Function
REQ-017 FSM states IDLE, BURST, DONE; registered state, outputs decoded from state.
REQ-018 IDLE: load -> addr_out <= data_in next edge; start has priority over load when both high.
REQ-019 IDLE, start with len != 0 -> BURST; capture len, stride, dir, bounds; addr_out unchanged (first beat = current address).
REQ-020 IDLE, start with len == 0 -> DONE directly; no beats issued, addr_out unchanged.
REQ-021 BURST: beat transfers when valid && ready; no ready -> addr_out and count held.
REQ-022 On transfer: count decrements; addr_out <= next address; when count == 1 at transfer -> DONE (addr_out still advances once more).
REQ-023 Next address without wrap: addr_out +/- stride modulo 2^ADDR_W (carry/borrow discarded).
REQ-024 DONE lasts exactly one cycle, then IDLE unconditionally.
REQ-025 load and start ignored in BURST and DONE; no queuing.
REQ-026 Beats per burst = captured len exactly; latency start -> first valid = 1 cycle.

Reset
REQ-027 rst low: state IDLE, addr_out 0, count 0, captured regs 0, valid/busy/done 0, immediately and regardless of clk.
REQ-028 rst asserted mid-burst aborts burst; no done pulse issued after release.
REQ-029 Release of rst: first active edge behaves as IDLE.

Configuration
REQ-030 Macro ADDR_SEQ_WRAP_EN defined: ascending next address > hi_bound (or carry out) -> lo_bound; descending next address < lo_bound (or borrow) -> hi_bound.
REQ-031 ADDR_SEQ_WRAP_EN undefined: lo_bound/hi_bound ports present but ignored; modulo behaviour per REQ-023.
REQ-032 With lo_bound > hi_bound, wrap behaviour is unspecified; bench does not exercise it.

Structure
REQ-033 Package addr_seq_pkg holds state enum (IDLE/BURST/DONE) and dir constants DIR_UP/DIR_DOWN.
REQ-034 Sub-module addr_step: combinational next-address (add/sub, carry, wrap compare), instantiated once.
REQ-035 FSM, counter and address register reside in addr_sequencer.

Verification
REQ-036 Reset: rst=0 during burst at addr 0x35 -> addr_out=0, valid=0, busy=0 same cycle; no done.
REQ-037 Load: IDLE, load=1, data_in=0xA5 -> addr_out=0xA5 next cycle; load during BURST -> no change.
REQ-038 Burst up: addr 0x10, len=4, stride=2, ready=1 -> beats 0x10,0x12,0x14,0x16; done pulse; final addr_out=0x18.
REQ-039 Backpressure: same burst, ready low cycles 2-3 -> addr_out held 0x12 two cycles, still 4 beats total.
REQ-040 Modulo/wrap: addr 0xFE, len=3, stride=1, up, bounds 0x00..0xFF/0xF0..0xFF -> without macro 0xFE,0xFF,0x00; with macro bounds 0xF0..0xFF -> 0xFE,0xFF,0xF0.
REQ-041 len=0 start -> busy=1, done=1 for one cycle, valid never high, addr_out unchanged.
